register_write_scheduler: RTL and testbench

- Buffers host register writes (voice-operator, global and sine-table) and issues them to the synth register write port only at safe points.
- Safe points are a bounded window after each sample boundary (i_SampleReady), or any cycle when immediate mode is on (e.g. initial patch load).
- Sits between the host interface (SPI/bus bridge) and the synth top's i_RegisterWrite* port, so configuration never changes mid-sample.

---
 rtl/synth_pkg.sv | 18 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/register_write_scheduler.sv | 107 ++++++++++
 tb/tb_register_write_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared synth register-write types.
// Register number/value widths, address-space bits, write bundle, scheduler states.
package synth_pkg;
  localparam int REG_NUMBER_WIDTH = 16;
  localparam int REG_VALUE_WIDTH = 16;
  localparam int REG_SPACE_VALID_BIT = 15;
  localparam int REG_SPACE_GLOBAL_BIT = 14;

  typedef struct packed {
    logic [REG_NUMBER_WIDTH-1:0] number;
    logic [REG_VALUE_WIDTH-1:0] value;
  } reg_write_t;

  typedef enum logic {
    IDLE,
    WINDOW
  } sched_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, no pass-through; head valid the cycle after push.
// Ports: clock/reset, push+data, pop, head data, full, empty, level.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     i_Push,
  input  logic [WIDTH-1:0]         i_PushData,
  input  logic                     i_Pop,
  output logic [WIDTH-1:0]         o_HeadData,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic doPush;
  logic doPop;

  assign o_Full = (o_Level == FULL_LEVEL);
  assign o_Empty = (o_Level == '0);
  assign doPush = i_Push && !o_Full;
  assign doPop = i_Pop && !o_Empty;
  assign o_HeadData = mem[rdPtr];

  always_ff @(posedge i_Clock) begin
    if (doPush) mem[wrPtr] <= i_PushData;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      o_Level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop) o_Level <= o_Level + 1'b1;
      else if (doPop && !doPush) o_Level <= o_Level - 1'b1;
    end
  end
endmodule

// File: rtl/register_write_scheduler.sv
// Buffers host register writes; issues them only in a window after a
// sample boundary or when immediate mode is on. Invalid numbers are dropped.
module register_write_scheduler
  import synth_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int WINDOW_CYCLES = 16
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset_n,
  input  logic                        i_HostWriteValid,
  output logic                        o_HostWriteReady,
  input  logic [15:0]                 i_HostWriteNumber,
  input  logic [15:0]                 i_HostWriteValue,
  input  logic                        i_SampleReady,
  input  logic                        i_ImmediateMode,
  output logic                        o_RegisterWriteEnable,
  output logic [15:0]                 o_RegisterWriteNumber,
  output logic [15:0]                 o_RegisterWriteValue,
  output logic [$clog2(FIFO_DEPTH):0] o_FifoLevel,
  output logic [7:0]                  o_DropCount,
  output logic                        o_Busy
);
  localparam int CW = $clog2(WINDOW_CYCLES + 1);
  localparam logic [CW-1:0] WINDOW_LOAD = CW'(WINDOW_CYCLES);
  localparam logic [CW-1:0] WINDOW_LAST = CW'(1);

  sched_state_e state;
  logic [CW-1:0] windowCount;
  logic readyEnable;
  logic fifoFull;
  logic fifoEmpty;
  logic popPermit;
  logic doPop;
  logic headValid;
  reg_write_t pushEntry;
  reg_write_t headEntry;

  assign pushEntry = '{number: i_HostWriteNumber, value: i_HostWriteValue};
  // Ready held low until the first clock after reset release.
  assign o_HostWriteReady = readyEnable && !fifoFull;
  assign popPermit = (state == WINDOW) || i_ImmediateMode;
  assign doPop = popPermit && !fifoEmpty;
  assign headValid = headEntry.number[REG_SPACE_VALID_BIT];
  assign o_Busy = (o_FifoLevel != '0) || o_RegisterWriteEnable;

  sync_fifo #(
    .WIDTH($bits(reg_write_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Push    (i_HostWriteValid && o_HostWriteReady),
    .i_PushData(pushEntry),
    .i_Pop     (doPop),
    .o_HeadData(headEntry),
    .o_Full    (fifoFull),
    .o_Empty   (fifoEmpty),
    .o_Level   (o_FifoLevel)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= IDLE;
      windowCount <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_SampleReady) begin
            state <= WINDOW;
            windowCount <= WINDOW_LOAD;
          end
        end
        WINDOW: begin
          if (i_SampleReady) begin
            windowCount <= WINDOW_LOAD;
          end else if (windowCount == WINDOW_LAST) begin
            state <= IDLE;
            windowCount <= '0;
          end else begin
            windowCount <= windowCount - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      readyEnable <= 1'b0;
      o_RegisterWriteEnable <= 1'b0;
      o_RegisterWriteNumber <= '0;
      o_RegisterWriteValue <= '0;
      o_DropCount <= '0;
    end else begin
      readyEnable <= 1'b1;
      o_RegisterWriteEnable <= doPop && headValid;
      if (doPop && headValid) begin
        o_RegisterWriteNumber <= headEntry.number;
        o_RegisterWriteValue <= headEntry.value;
      end
      if (doPop && !headValid && o_DropCount != 8'hFF)
        o_DropCount <= o_DropCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_register_write_scheduler.sv
// Self-checking bench: queue-based reference model plus directed
// and randomized stimulus for register_write_scheduler.
module tb_register_write_scheduler;
  localparam int DEPTH = 8;
  localparam int WIN = 16;

  logic clk = 0;
  logic rst_n = 0;
  logic valid = 0;
  logic rdy;
  logic [15:0] num = 0;
  logic [15:0] val = 0;
  logic sr = 0;
  logic imm = 0;
  logic en;
  logic [15:0] onum;
  logic [15:0] oval;
  logic [3:0] level;
  logic [7:0] drop;
  logic busy;

  int errors = 0;
  int checks = 0;
  int enCount = 0;

  register_write_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .WINDOW_CYCLES(WIN)
  ) dut (
    .i_Clock              (clk),
    .i_Reset_n            (rst_n),
    .i_HostWriteValid     (valid),
    .o_HostWriteReady     (rdy),
    .i_HostWriteNumber    (num),
    .i_HostWriteValue     (val),
    .i_SampleReady        (sr),
    .i_ImmediateMode      (imm),
    .o_RegisterWriteEnable(en),
    .o_RegisterWriteNumber(onum),
    .o_RegisterWriteValue (oval),
    .o_FifoLevel          (level),
    .o_DropCount          (drop),
    .o_Busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes and a count of
  // remaining pop slots in the current window.
  logic [31:0] q[$];
  int win = 0;
  bit mRdyFlag = 0;
  bit pushOk;
  logic mEn = 0;
  logic [15:0] mNum = 0;
  logic [15:0] mVal = 0;
  int mDrop = 0;
  logic [31:0] e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      win = 0;
      mRdyFlag = 0;
      mEn = 0;
      mNum = 0;
      mVal = 0;
      mDrop = 0;
    end else begin
      pushOk = valid && mRdyFlag && (q.size() < DEPTH);
      mEn = 0;
      if ((imm || win > 0) && q.size() > 0) begin
        e = q.pop_front();
        if (e[31]) begin
          mEn = 1;
          mNum = e[31:16];
          mVal = e[15:0];
        end else if (mDrop < 255) begin
          mDrop++;
        end
      end
      if (pushOk) q.push_back({num, val});
      win = sr ? WIN : (win > 0 ? win - 1 : 0);
      mRdyFlag = 1;
    end
  end

  always @(negedge clk) begin
    chk("enable", 32'(en), 32'(mEn));
    chk("number", 32'(onum), 32'(mNum));
    chk("value", 32'(oval), 32'(mVal));
    chk("level", 32'(level), 32'(q.size()));
    chk("drop", 32'(drop), 32'(mDrop));
    chk("busy", 32'(busy), 32'((q.size() != 0) || mEn));
    chk("ready", 32'(rdy), 32'(mRdyFlag && q.size() < DEPTH));
    if (en) enCount++;
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic hostWrite(input logic [15:0] n, input logic [15:0] v);
    bit acc;
    bit done = 0;
    valid = 1;
    num = n;
    val = v;
    for (int i = 0; i < 2000 && !done; i++) begin
      acc = rdy;
      @(negedge clk);
      if (acc) done = 1;
    end
    if (!done) chk("host_accept_timeout", 0, 1);
    valid = 0;
  endtask

  task automatic pulse();
    sr = 1;
    @(negedge clk);
    sr = 0;
  endtask

  int c0;
  bit lastRdy;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_enable", 32'(en), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);
    #2 rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy), 1);

    // Writes held until a sample boundary.
    hostWrite(16'hC000, 16'h1234);
    hostWrite(16'hC100, 16'h0042);
    hostWrite(16'h8005, 16'h7FFF);
    c0 = enCount;
    repeat (50) @(negedge clk);
    #1;
    chk("no_issue_idle", 32'(enCount - c0), 0);
    chk("held_level", 32'(level), 3);
    pulse();
    chk("t1_n1_en", 32'(en), 0);
    @(negedge clk);
    chk("t1_w0", {15'(en), 1'b0, onum}, {16'h2, 16'hC000});
    chk("t1_v0", 32'(oval), 32'h1234);
    @(negedge clk);
    chk("t1_w1", {15'(en), 1'b0, onum}, {16'h2, 16'hC100});
    @(negedge clk);
    chk("t1_w2", {15'(en), 1'b0, onum}, {16'h2, 16'h8005});
    chk("t1_v2", 32'(oval), 32'h7FFF);
    @(negedge clk);
    chk("t1_done_en", 32'(en), 0);
    chk("t1_done_lvl", 32'(level), 0);
    repeat (20) @(negedge clk);

    // 20 writes through an 8-deep FIFO: 16 per window.
    fork
      for (int i = 0; i < 20; i++) hostWrite(16'hC000 | 16'(i), 16'(i * 3));
      begin
        for (int k = 0; k < 100 && level != 4'd8; k++) @(negedge clk);
        chk("full_level", 32'(level), 8);
        chk("full_ready", 32'(rdy), 0);
        c0 = enCount;
        pulse();
      end
    join
    repeat (25) @(negedge clk);
    #1;
    chk("window_issue16", 32'(enCount - c0), 16);
    chk("window_left4", 32'(level), 4);
    c0 = enCount;
    pulse();
    repeat (25) @(negedge clk);
    #1;
    chk("window2_issue4", 32'(enCount - c0), 4);
    chk("window2_lvl", 32'(level), 0);

    // Invalid entry between two valid ones.
    hostWrite(16'hC001, 16'h0001);
    hostWrite(16'h4000, 16'h0002);
    hostWrite(16'hC002, 16'h0003);
    pulse();
    @(negedge clk);
    chk("drop_w0", {15'(en), 1'b0, onum}, {16'h2, 16'hC001});
    @(negedge clk);
    chk("drop_gap", 32'(en), 0);
    @(negedge clk);
    chk("drop_w1", {15'(en), 1'b0, onum}, {16'h2, 16'hC002});
    chk("drop_one", 32'(drop), 1);
    repeat (20) @(negedge clk);

    // Saturation of the drop counter.
    imm = 1;
    for (int i = 0; i < 300; i++) hostWrite(16'(i), 16'(i));
    repeat (5) @(negedge clk);
    chk("drop_sat", 32'(drop), 255);
    chk("drop_sat_lvl", 32'(level), 0);

    // Immediate mode back-to-back issue.
    fork
      for (int i = 0; i < 5; i++) hostWrite(16'h8010 + 16'(i), 16'(i));
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          chk("imm_en", 32'(en), 1);
          chk("imm_num", 32'(onum), 32'(16'h8010 + 16'(i)));
          @(negedge clk);
        end
        chk("imm_end", 32'(en), 0);
      end
    join
    imm = 0;
    repeat (5) @(negedge clk);

    // Reset mid-window with writes queued and a strobe in flight.
    for (int i = 0; i < 4; i++) hostWrite(16'hC200 | 16'(i), 16'(i));
    pulse();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rstmid_en", 32'(en), 0);
    chk("rstmid_lvl", 32'(level), 0);
    chk("rstmid_busy", 32'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    c0 = enCount;
    pulse();
    repeat (20) @(negedge clk);
    #1;
    chk("rstmid_noissue", 32'(enCount - c0), 0);
    chk("rstmid_lvl2", 32'(level), 0);

    // Randomized traffic against the model.
    @(negedge clk);
    lastRdy = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!valid || lastRdy) begin
        valid = ($urandom % 3) != 0;
        num = {1'(($urandom % 5) != 0), 15'($urandom)};
        val = 16'($urandom);
      end
      sr = ($urandom % 20) == 0;
      if (($urandom % 100) == 0) imm = ~imm;
      lastRdy = rdy;
      @(negedge clk);
    end
    valid = 0;
    sr = 0;
    imm = 1;
    repeat (20) @(negedge clk);
    chk("final_drain", 32'(level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
